// File: rtl/adc_capture_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture_buffer_pkg : capture state encodings and default sizes
// Revision 1.0
// ---------------------------------------------------------------------------
package adc_capture_buffer_pkg;

  localparam int DW_DEFAULT       = 8;
  localparam int AW_DEFAULT       = 8;
  localparam int PRE_TRIG_DEFAULT = 32;

  typedef enum logic [2:0] {
    CAP_IDLE  = 3'd0,
    CAP_PRE   = 3'd1,
    CAP_ARMED = 3'd2,
    CAP_POST  = 3'd3,
    CAP_DONE  = 3'd4
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_capture_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture_buffer_if : ADC sample, trigger control and readout signals
// Revision 1.0
// ---------------------------------------------------------------------------
interface adc_capture_buffer_if
  import adc_capture_buffer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);
  logic          adc_clk;
  logic [DW-1:0] adc_data;
  logic          arm;
  logic [DW-1:0] trig_level;
  logic          trig_fall;
  logic          rd_next;
  logic [DW-1:0] txd_data;
  logic          busy;
  logic          ready;

  modport slave (
    input  adc_clk, adc_data, arm, trig_level, trig_fall, rd_next,
    output txd_data, busy, ready
  );

  modport master (
    output adc_clk, adc_data, arm, trig_level, trig_fall, rd_next,
    input  txd_data, busy, ready
  );
endinterface
`default_nettype wire

// File: rtl/adc_capture_buffer_capture_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capture_ram : simple dual-port sample RAM, one write port, registered read
// Revision 1.0
// ---------------------------------------------------------------------------
module capture_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  // No reset on the array or read register so the tools can map it to block RAM
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture_buffer : triggered ADC recorder with pre-trigger history and
//                      byte-wise readout of the frozen record
// Revision 1.0
// ---------------------------------------------------------------------------
module adc_capture_buffer
  import adc_capture_buffer_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int PRE_TRIG = PRE_TRIG_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  adc_capture_buffer_if.slave bus
);
  localparam int            DEPTH    = 1 << AW;
  localparam int            POST_LEN = DEPTH - PRE_TRIG;
  localparam logic [AW-1:0] PRE_END  = AW'(PRE_TRIG);
  localparam logic [AW:0]   POST_END = (AW+1)'(POST_LEN);
  localparam logic [AW-1:0] RD_END   = {AW{1'b1}};

  cap_state_t    state;
  logic          sync1;
  logic          sync2;
  logic [DW-1:0] data_q;
  logic [DW-1:0] prev;
  logic          prev_valid;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW:0]   post_cnt;
  logic [AW-1:0] rd_cnt;
  logic          busy_q;
  logic          ready_q;
  logic [DW-1:0] txd_q;

  logic          s_edge;
  logic [DW-1:0] cur;
  logic          rise_hit;
  logic          fall_hit;
  logic          hit;
  logic          pre_done;
  logic          hunting;
  logic          recording;
  logic          take;
  logic          done_go;
  logic [AW-1:0] trig_base;
  logic [AW-1:0] rp_nxt;
  logic [DW-1:0] rd_data;

  assign s_edge    = sync1 & ~sync2;
  assign cur       = data_q;
  assign rise_hit  = (prev < bus.trig_level) && (cur >= bus.trig_level);
  assign fall_hit  = (prev > bus.trig_level) && (cur <= bus.trig_level);
  assign hit       = prev_valid && (bus.trig_fall ? fall_hit : rise_hit);
  assign pre_done  = (pre_cnt == PRE_END);
  assign hunting   = (state == CAP_ARMED) || ((state == CAP_PRE) && pre_done);
  assign recording = (state == CAP_PRE) || (state == CAP_ARMED) || (state == CAP_POST);
  // A sample coinciding with arm belongs to neither the old nor the new capture
  assign take      = s_edge && recording && !bus.arm;

  // A one-sample post window finishes on the trigger sample itself
  assign done_go = take &&
                   ((hunting && hit && (POST_END == (AW+1)'(1))) ||
                    ((state == CAP_POST) && ((post_cnt + 1'b1) == POST_END)));
  assign trig_base = (state == CAP_POST) ? trig_ptr : wp;

  // The RAM is addressed with the next read pointer so the byte is ready one clock later
  always_comb begin
    rp_nxt = rp;
    if (done_go) begin
      rp_nxt = trig_base - PRE_END;
    end else if ((state == CAP_DONE) && bus.rd_next && !bus.arm) begin
      rp_nxt = rp + 1'b1;
    end
  end

  capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (take),
    .waddr (wp),
    .wdata (cur),
    .raddr (rp_nxt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= CAP_IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      data_q     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      trig_ptr   <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      txd_q      <= '0;
    end else begin
      sync1  <= bus.adc_clk;
      sync2  <= sync1;
      data_q <= bus.adc_data;
      rp     <= rp_nxt;

      if (state == CAP_DONE) begin
        txd_q <= rd_data;
      end

      if (bus.arm) begin
        state      <= CAP_PRE;
        busy_q     <= 1'b1;
        ready_q    <= 1'b0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        rd_cnt     <= '0;
        prev_valid <= 1'b0;
      end else begin
        if (take) begin
          wp         <= wp + 1'b1;
          prev       <= cur;
          prev_valid <= 1'b1;
        end

        case (state)
          CAP_PRE, CAP_ARMED: begin
            if (hunting) begin
              state <= CAP_ARMED;
              if (take && hit) begin
                trig_ptr <= wp;
                post_cnt <= (AW+1)'(1);
                state    <= CAP_POST;
              end
            end else if (take) begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          CAP_POST: begin
            if (take) begin
              post_cnt <= post_cnt + 1'b1;
            end
          end
          CAP_DONE: begin
            if (bus.rd_next) begin
              rd_cnt <= rd_cnt + 1'b1;
              if (rd_cnt == RD_END) begin
                state   <= CAP_IDLE;
                ready_q <= 1'b0;
              end
            end
          end
          default: ;
        endcase

        if (done_go) begin
          state   <= CAP_DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          rd_cnt  <= '0;
        end
      end
    end
  end

  assign bus.txd_data = txd_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
endmodule
`default_nettype wire
